// File: rtl/constant_r_t_n0prime_if.sv
// ---------------------------------------------------------------------------
// constant_r_t_n0prime_if
//   Bundles the request and result signals of the Montgomery precompute
//   engine (constant_r_t_n0prime).
//
//   start         requester -> engine  1-cycle start request
//   n             requester -> engine  modulus, DATA_LENGTH bits
//   r_out         engine -> requester  2^L mod n
//   t_out         engine -> requester  2^(2L) mod n
//   n0prime       engine -> requester  -n^-1 mod 2^W
//   r_t_done      engine -> requester  r_out/t_out valid (level)
//   n0prime_done  engine -> requester  n0prime valid (level)
//   done          engine -> requester  both results valid (level)
//   err_n         engine -> requester  invalid-modulus flag
//
//   modport master : the requester side
//   modport slave  : the engine side
// ---------------------------------------------------------------------------
interface constant_r_t_n0prime_if #(
    parameter int DATA_LENGTH = 1024,
    parameter int DATA_WIDTH  = 32
);
    logic                   start;
    logic [DATA_LENGTH-1:0] n;
    logic [DATA_LENGTH-1:0] r_out;
    logic [DATA_LENGTH-1:0] t_out;
    logic [DATA_WIDTH-1:0]  n0prime;
    logic                   r_t_done;
    logic                   n0prime_done;
    logic                   done;
    logic                   err_n;

    modport master (
        output start, n,
        input  r_out, t_out, n0prime, r_t_done, n0prime_done, done, err_n
    );

    modport slave (
        input  start, n,
        output r_out, t_out, n0prime, r_t_done, n0prime_done, done, err_n
    );
endinterface

// File: rtl/constant_r_t_n0prime.sv
// ---------------------------------------------------------------------------
// constant_r_t_n0prime
//   Montgomery precompute engine. From a modulus n it produces
//     r       = 2^L  mod n        (L = DATA_LENGTH)
//     t       = 2^2L mod n
//     n0prime = -n[W-1:0]^-1 mod 2^W   (W = DATA_WIDTH)
//   using two bit-serial datapaths launched by the same start.
//   r/t take 2L cycles after the accept edge, n0prime takes W cycles.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears all state and outputs
//   bus    constant_r_t_n0prime_if.slave (start, n, results, done flags)
//
// Optional feature
//   CONST_RT_NCHECK_EN : when defined, err_n flags an even modulus or
//   n <= 1 at accept. When undefined, err_n is tied to 0.
// ---------------------------------------------------------------------------
module constant_r_t_n0prime #(
    parameter int DATA_LENGTH = 1024,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    constant_r_t_n0prime_if.slave   bus
);

    localparam int CW = $clog2(2 * DATA_LENGTH);
    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] R_LAST = CW'(DATA_LENGTH - 1);
    localparam logic [CW-1:0] T_LAST = CW'(2 * DATA_LENGTH - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_WIDTH);
    localparam logic [DATA_LENGTH-1:0] N_ONE = {{(DATA_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]  Y_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {RT_IDLE, RT_CALC_R, RT_CALC_T, RT_DONE} rt_state_t;
    typedef enum logic [1:0] {NP_IDLE, NP_CALC, NP_DONE} np_state_t;

    // One modular doubling step: 2v, minus m when 2v >= m, all at L+1 bits.
    function automatic logic [DATA_LENGTH:0] mod_double(
        input logic [DATA_LENGTH:0]   v,
        input logic [DATA_LENGTH-1:0] m
    );
        logic [DATA_LENGTH:0] d;
        logic [DATA_LENGTH:0] mx;
        d  = v << 1;
        mx = {1'b0, m};
        return (d >= mx) ? (d - mx) : d;
    endfunction

    rt_state_t              rt_state_q, rt_state_d;
    np_state_t              np_state_q, np_state_d;
    logic [DATA_LENGTH-1:0] n_q, n_d;
    logic [DATA_LENGTH:0]   v_q, v_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_LENGTH-1:0] r_q, r_d;
    logic [DATA_LENGTH-1:0] t_q, t_d;
    logic                   rt_done_q, rt_done_d;
    logic [DATA_WIDTH-1:0]  y_q, y_d;
    logic [IW-1:0]          i_q, i_d;
    logic [DATA_WIDTH-1:0]  np_q, np_d;
    logic                   np_done_q, np_done_d;

    logic                   accept;
    logic [DATA_LENGTH:0]   v_step;
    logic [DATA_WIDTH-1:0]  prod;
    logic [BW-1:0]          bit_idx;

    // A new request is taken only when neither datapath is mid-run.
    assign accept = bus.start
                  && (rt_state_q == RT_IDLE || rt_state_q == RT_DONE)
                  && (np_state_q == NP_IDLE || np_state_q == NP_DONE);

    assign v_step  = mod_double(v_q, n_q);
    assign prod    = n_q[DATA_WIDTH-1:0] * y_q;
    assign bit_idx = i_q[BW-1:0];

    // r/t datapath: L doublings give r, L more give t
    always_comb begin
        rt_state_d = rt_state_q;
        n_d        = n_q;
        v_d        = v_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        t_d        = t_q;
        rt_done_d  = rt_done_q;
        if (accept) begin
            n_d        = bus.n;
            // 2^0 mod 1 is 0, so the accumulator starts at 0 for n == 1.
            v_d        = {{DATA_LENGTH{1'b0}}, (bus.n != N_ONE)};
            cnt_d      = '0;
            r_d        = '0;
            t_d        = '0;
            rt_done_d  = 1'b0;
            rt_state_d = RT_CALC_R;
        end else begin
            case (rt_state_q)
                RT_CALC_R: begin
                    v_d   = v_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == R_LAST) begin
                        r_d        = v_step[DATA_LENGTH-1:0];
                        rt_state_d = RT_CALC_T;
                    end
                end
                RT_CALC_T: begin
                    v_d = v_step;
                    if (cnt_q == T_LAST) begin
                        t_d        = v_step[DATA_LENGTH-1:0];
                        rt_done_d  = 1'b1;
                        cnt_d      = '0;
                        rt_state_d = RT_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // n0prime datapath: Hensel lifting of the inverse one bit per cycle,
    // bits 1..W-1, then negate on the W-th cycle.
    always_comb begin
        np_state_d = np_state_q;
        y_d        = y_q;
        i_d        = i_q;
        np_d       = np_q;
        np_done_d  = np_done_q;
        if (accept) begin
            y_d        = Y_ONE;
            i_d        = {{(IW-1){1'b0}}, 1'b1};
            np_d       = '0;
            np_done_d  = 1'b0;
            np_state_d = NP_CALC;
        end else if (np_state_q == NP_CALC) begin
            if (i_q == I_LAST) begin
                np_d       = ~y_q + Y_ONE;
                np_done_d  = 1'b1;
                np_state_d = NP_DONE;
            end else begin
                if (prod[bit_idx]) begin
                    y_d[bit_idx] = 1'b1;
                end
                i_d = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rt_state_q <= RT_IDLE;
            np_state_q <= NP_IDLE;
            n_q        <= '0;
            v_q        <= '0;
            cnt_q      <= '0;
            r_q        <= '0;
            t_q        <= '0;
            rt_done_q  <= 1'b0;
            y_q        <= '0;
            i_q        <= '0;
            np_q       <= '0;
            np_done_q  <= 1'b0;
        end else begin
            rt_state_q <= rt_state_d;
            np_state_q <= np_state_d;
            n_q        <= n_d;
            v_q        <= v_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            t_q        <= t_d;
            rt_done_q  <= rt_done_d;
            y_q        <= y_d;
            i_q        <= i_d;
            np_q       <= np_d;
            np_done_q  <= np_done_d;
        end
    end

`ifdef CONST_RT_NCHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = (bus.n[0] == 1'b0) || (bus.n <= N_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err_n = err_q;
`else
    assign bus.err_n = 1'b0;
`endif

    assign bus.r_out        = r_q;
    assign bus.t_out        = t_q;
    assign bus.n0prime      = np_q;
    assign bus.r_t_done     = rt_done_q;
    assign bus.n0prime_done = np_done_q;
    assign bus.done         = rt_done_q & np_done_q;

endmodule

// File: tb/tb_constant_r_t_n0prime.sv
module tb_constant_r_t_n0prime;
    localparam int L = 1024;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    constant_r_t_n0prime_if #(.DATA_LENGTH(L), .DATA_WIDTH(W)) bus ();

    constant_r_t_n0prime #(.DATA_LENGTH(L), .DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [L-1:0] n;
        logic [L-1:0] r;
        logic [L-1:0] t;
        logic [W-1:0] np;
    } vec_t;

    vec_t vecs[3];

    task automatic chk_vec(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (low 128 bits shown)",
                     name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_err(input logic [L-1:0] nv);
`ifdef CONST_RT_NCHECK_EN
        return (nv[0] == 1'b0) || (nv <= L'(1));
`else
        return (nv[0] == 1'b0) && 1'b0;
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk_vec({tag, "_r"}, bus.r_out, '0);
        chk_vec({tag, "_t"}, bus.t_out, '0);
        chk_vec({tag, "_np"}, L'(bus.n0prime), '0);
        chk_bit({tag, "_rtd"}, bus.r_t_done, 1'b0);
        chk_bit({tag, "_npd"}, bus.n0prime_done, 1'b0);
        chk_bit({tag, "_done"}, bus.done, 1'b0);
        chk_bit({tag, "_err"}, bus.err_n, 1'b0);
    endtask

    // Called #1 after a rising edge; the start is taken at the next edge (k).
    task automatic run(input logic [L-1:0] nv, input logic [L-1:0] er, input logic [L-1:0] et,
                       input logic [W-1:0] enp, input bit pulse5);
        int np_at = -1;
        int rt_at = -1;
        int dn_at = -1;
        bus.start = 1'b1;
        bus.n     = nv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.n     = ~nv;
        chk_bit("accept_done_clr", bus.done, 1'b0);
        chk_bit("accept_rtd_clr", bus.r_t_done, 1'b0);
        chk_bit("accept_npd_clr", bus.n0prime_done, 1'b0);
        chk_vec("accept_r_clr", bus.r_out, '0);
        chk_bit("accept_err", bus.err_n, exp_err(nv));
        for (int c = 1; c <= 2 * L + 8; c++) begin
            if (pulse5 && c == 100) begin
                bus.start = 1'b1;
                bus.n     = L'(5);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (c == L - 1) chk_vec("r_before_L", bus.r_out, '0);
            if (c == L)     chk_vec("r_at_L", bus.r_out, er);
            if (np_at < 0 && bus.n0prime_done) np_at = c;
            if (rt_at < 0 && bus.r_t_done)     rt_at = c;
            if (dn_at < 0 && bus.done)         dn_at = c;
            if (dn_at >= 0) break;
        end
        chk_int("np_done_cycle", np_at, W);
        chk_int("rt_done_cycle", rt_at, 2 * L);
        chk_int("done_cycle", dn_at, 2 * L);
        chk_vec("r_out", bus.r_out, er);
        chk_vec("t_out", bus.t_out, et);
        chk_vec("n0prime", L'(bus.n0prime), L'(enp));
        chk_bit("err_n", bus.err_n, exp_err(nv));
    endtask

    initial begin
        vecs[0].n  = L'(3);
        vecs[0].r  = L'(1);
        vecs[0].t  = L'(1);
        vecs[0].np = 32'h5555_5555;
        vecs[1].n  = {L{1'b1}};
        vecs[1].r  = L'(1);
        vecs[1].t  = L'(1);
        vecs[1].np = 32'h0000_0001;
        vecs[2].n  = {1'b1, {(L-2){1'b0}}, 1'b1};
        vecs[2].r  = {1'b0, {(L-1){1'b1}}};
        vecs[2].t  = L'(4);
        vecs[2].np = 32'hFFFF_FFFF;

        // Reset held for three cycles, with start asserted: reset wins.
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.n     = L'(3);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk_all_zero("idle");

        // Back-to-back runs: each next start lands on the cycle done is high.
        for (int i = 0; i < 3; i++) begin
            run(vecs[i].n, vecs[i].r, vecs[i].t, vecs[i].np, 1'b0);
        end

        // A start while busy (n = 5 at k+100) must be ignored.
        run(vecs[2].n, vecs[2].r, vecs[2].t, vecs[2].np, 1'b1);

        // Reset in the middle of a run, start asserted during reset.
        bus.start = 1'b1;
        bus.n     = vecs[1].n;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (1499) @(posedge clk);
        #1;
        chk_vec("pre_reset_r", bus.r_out, L'(1));
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        bus.start = 1'b1;
        bus.n     = L'(3);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("midreset_hold");
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk_all_zero("post_reset");
        run(vecs[0].n, vecs[0].r, vecs[0].t, vecs[0].np, 1'b0);

`ifdef CONST_RT_NCHECK_EN
        // n = 4 flags an invalid modulus from k+1; r and t both reduce to 0.
        bus.start = 1'b1;
        bus.n     = L'(4);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk_bit("err_n_even", bus.err_n, 1'b1);
        for (int c = 0; c < 2 * L + 8; c++) begin
            if (bus.done) break;
            @(posedge clk); #1;
        end
        chk_bit("even_done", bus.done, 1'b1);
        chk_vec("even_r", bus.r_out, '0);
        chk_bit("err_n_hold", bus.err_n, 1'b1);
        run(vecs[0].n, vecs[0].r, vecs[0].t, vecs[0].np, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
